// File: rtl/decode_issue.sv
// decode_issue: ID->EX pipeline register sitting directly after the
// 32x32 register file.
//
// Each cycle it:
//   - drives the register file read addresses straight from the fetch bundle
//   - resolves both operands, forwarding from EX, MEM and WB
//   - detects a load-use hazard, stalls fetch and inserts a bubble
//   - registers a decoded bundle (pc, instr, operands, immediate,
//     destination, load flag) for the execute stage
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   delay                 global freeze; every register holds its value
//   flush                 taken branch/jump in EX; the bundle entering ID/EX is killed
//   if_valid/instr/pc     fetch bundle
//   rin1, rin2            register file read addresses (combinational)
//   rout1, rout2          register file read data
//   ex_*, mem_*, wb_*     forwarding sources from the later stages
//   stall_if              hold PC and fetch bundle (load-use hazard)
//   id_*                  registered decoded bundle for execute
module decode_issue #(
  parameter int XLEN      = 32,
  parameter int NREG_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 delay,
  input  logic                 flush,
  input  logic                 if_valid,
  input  logic [31:0]          if_instr,
  input  logic [31:0]          if_pc,
  output logic [NREG_BITS-1:0] rin1,
  output logic [NREG_BITS-1:0] rin2,
  input  logic [XLEN-1:0]      rout1,
  input  logic [XLEN-1:0]      rout2,
  input  logic                 ex_we,
  input  logic                 ex_is_load,
  input  logic [NREG_BITS-1:0] ex_waddr,
  input  logic [XLEN-1:0]      ex_result,
  input  logic                 mem_we,
  input  logic [NREG_BITS-1:0] mem_waddr,
  input  logic [XLEN-1:0]      mem_result,
  input  logic                 wb_we,
  input  logic [NREG_BITS-1:0] wb_waddr,
  input  logic [XLEN-1:0]      wb_win,
  output logic                 stall_if,
  output logic                 id_valid,
  output logic [31:0]          id_pc,
  output logic [31:0]          id_instr,
  output logic [XLEN-1:0]      id_op1,
  output logic [XLEN-1:0]      id_op2,
  output logic [XLEN-1:0]      id_imm,
  output logic [NREG_BITS-1:0] id_rd,
  output logic                 id_is_load
);

  logic [5:0]           opcode;
  logic                 hazard;
  logic [XLEN-1:0]      op1_next;
  logic [XLEN-1:0]      op2_next;
  logic [XLEN-1:0]      imm_next;
  logic [NREG_BITS-1:0] rd_next;

  assign opcode = if_instr[31:26];
  assign rin1   = if_instr[25:21];
  assign rin2   = if_instr[20:16];

  // A load still in EX has no data yet: bubble once, then the value
  // arrives through the MEM forward. Register 0 never hazards.
  assign hazard = if_valid & ex_is_load & ex_we & (ex_waddr != '0) &
                  ((ex_waddr == rin1) | (ex_waddr == rin2));
  assign stall_if = hazard;

  // Youngest producer wins. The WB path is required because the
  // register file writes on the same edge we read, so rout is stale.
  function automatic logic [XLEN-1:0] resolve(
    input logic [NREG_BITS-1:0] addr,
    input logic [XLEN-1:0]      rout
  );
    if (addr == '0)
      resolve = '0;
    else if (ex_we && ex_waddr == addr && !ex_is_load)
      resolve = ex_result;
    else if (mem_we && mem_waddr == addr)
      resolve = mem_result;
    else if (wb_we && wb_waddr == addr)
      resolve = wb_win;
    else
      resolve = rout;
  endfunction

  assign op1_next = resolve(rin1, rout1);
  assign op2_next = resolve(rin2, rout2);

  always_comb begin
    imm_next = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};
    case (opcode)
      6'h0C, 6'h0D, 6'h0E: imm_next = {{(XLEN-16){1'b0}}, if_instr[15:0]};
      6'h0F:               imm_next = {if_instr[15:0], {(XLEN-16){1'b0}}};
      default:             ;
    endcase
  end

  always_comb begin
    rd_next = if_instr[20:16];
    case (opcode)
      6'h00:                      rd_next = if_instr[15:11];
      6'h03:                      rd_next = {NREG_BITS{1'b1}};
      6'h2B, 6'h04, 6'h05, 6'h02: rd_next = '0;
      default:                    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid   <= 1'b0;
      id_pc      <= '0;
      id_instr   <= '0;
      id_op1     <= '0;
      id_op2     <= '0;
      id_imm     <= '0;
      id_rd      <= '0;
      id_is_load <= 1'b0;
    end else if (delay) begin
      // freeze: hold everything
    end else if (flush || hazard) begin
      // bubble; payload fields are don't-care and simply held
      id_valid <= 1'b0;
    end else begin
      id_valid   <= if_valid;
      id_pc      <= if_pc;
      id_instr   <= if_instr;
      id_op1     <= op1_next;
      id_op2     <= op2_next;
      id_imm     <= imm_next;
      id_rd      <= rd_next;
      id_is_load <= (opcode == 6'h23);
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
module tb_decode_issue;
  logic        clk;
  logic        reset, delay, flush, if_valid;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  rin1, rin2;
  logic [31:0] rout1, rout2;
  logic        ex_we, ex_is_load;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_result;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_result;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_win;
  logic        stall_if, id_valid;
  logic [31:0] id_pc, id_instr, id_op1, id_op2, id_imm;
  logic [4:0]  id_rd;
  logic        id_is_load;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADD    = 32'h0022_1820; // add  r3,r1,r2
  localparam logic [31:0] I_ADD_R0 = 32'h0020_1820; // add  r3,r1,r0
  localparam logic [31:0] I_ADDI   = 32'h2085_FFFF; // addi r5,r4,-1
  localparam logic [31:0] I_ORI    = 32'h3406_8000; // ori  r6,r0,0x8000
  localparam logic [31:0] I_LUI    = 32'h3C07_8000; // lui  r7,0x8000
  localparam logic [31:0] I_SW     = 32'hAC22_0000; // sw   r2,0(r1)
  localparam logic [31:0] I_JAL    = 32'h0C00_0010; // jal
  localparam logic [31:0] I_LW     = 32'h8C24_0004; // lw   r4,4(r1)

  decode_issue dut (
    .clk(clk), .reset(reset), .delay(delay), .flush(flush),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .rin1(rin1), .rin2(rin2), .rout1(rout1), .rout2(rout2),
    .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_result(ex_result),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_result(mem_result),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_win(wb_win),
    .stall_if(stall_if), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_op1(id_op1), .id_op2(id_op2), .id_imm(id_imm), .id_rd(id_rd),
    .id_is_load(id_is_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    ex_we = 0; ex_is_load = 0; ex_waddr = 0; ex_result = 0;
    mem_we = 0; mem_waddr = 0; mem_result = 0;
    wb_we = 0; wb_waddr = 0; wb_win = 0;
  endtask

  initial begin
    reset = 1; delay = 0; flush = 0;
    if_valid = 1; if_instr = I_ADD; if_pc = 32'h100;
    rout1 = 5; rout2 = 7;
    clear_fwd();

    // reset with a valid bundle present
    step();
    check("rst_valid", {31'b0, id_valid}, 32'h0);
    check("rst_op1", id_op1, 32'h0);
    check("rst_rd", {27'b0, id_rd}, 32'h0);

    // plain issue from the register file
    reset = 0;
    step();
    check("add_valid", {31'b0, id_valid}, 32'h1);
    check("add_op1", id_op1, 32'd5);
    check("add_op2", id_op2, 32'd7);
    check("add_rd", {27'b0, id_rd}, 32'd3);
    check("add_pc", id_pc, 32'h100);

    // EX beats MEM, then MEM when EX stops writing
    ex_we = 1; ex_waddr = 1; ex_result = 32'h11;
    mem_we = 1; mem_waddr = 1; mem_result = 32'h22;
    if_pc = 32'h104;
    step();
    check("exfwd_op1", id_op1, 32'h11);
    check("exfwd_op2", id_op2, 32'd7);
    ex_we = 0;
    step();
    check("memfwd_op1", id_op1, 32'h22);

    // load-use: lw r4 in EX, addi r5,r4,-1 in ID
    clear_fwd();
    ex_we = 1; ex_is_load = 1; ex_waddr = 4; ex_result = 32'hDEAD;
    if_instr = I_ADDI; if_pc = 32'h108;
    #1;
    check("lu_stall", {31'b0, stall_if}, 32'h1);
    step();
    check("lu_bubble", {31'b0, id_valid}, 32'h0);
    clear_fwd();
    mem_we = 1; mem_waddr = 4; mem_result = 9;
    #1;
    check("lu_nostall", {31'b0, stall_if}, 32'h0);
    step();
    check("lu_valid", {31'b0, id_valid}, 32'h1);
    check("lu_op1", id_op1, 32'd9);
    check("lu_imm", id_imm, 32'hFFFF_FFFF);
    check("lu_rd", {27'b0, id_rd}, 32'd5);

    // no hazard against r0, nor without a valid bundle
    clear_fwd();
    ex_we = 1; ex_is_load = 1; ex_waddr = 0;
    if_instr = I_ORI;
    #1;
    check("lu_r0", {31'b0, stall_if}, 32'h0);
    ex_waddr = 4; if_instr = I_ADDI; if_valid = 0;
    #1;
    check("lu_novalid", {31'b0, stall_if}, 32'h0);
    if_valid = 1;

    // WB bypass
    clear_fwd();
    wb_we = 1; wb_waddr = 2; wb_win = 32'hAB;
    if_instr = I_ADD; rout2 = 0;
    step();
    check("wb_op2", id_op2, 32'hAB);

    // r0 always reads zero whatever is forwarded
    clear_fwd();
    ex_we = 1; ex_waddr = 0; ex_result = 32'h55;
    mem_we = 1; mem_waddr = 0; mem_result = 32'h66;
    wb_we = 1; wb_waddr = 0; wb_win = 32'h77;
    rout2 = 32'h88; if_instr = I_ADD_R0;
    step();
    check("r0_op2", id_op2, 32'h0);

    // ori then a 3-cycle freeze with a different bundle presented
    clear_fwd();
    if_instr = I_ORI; if_pc = 32'h200;
    step();
    check("ori_imm", id_imm, 32'h0000_8000);
    check("ori_rd", {27'b0, id_rd}, 32'd6);
    delay = 1; if_instr = I_LUI; if_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      step();
      check("dly_valid", {31'b0, id_valid}, 32'h1);
      check("dly_imm", id_imm, 32'h0000_8000);
      check("dly_pc", id_pc, 32'h200);
    end
    delay = 0; flush = 1;
    step();
    check("flush_valid", {31'b0, id_valid}, 32'h0);

    // flush coinciding with a hazard still bubbles
    ex_we = 1; ex_is_load = 1; ex_waddr = 4; if_instr = I_ADDI;
    step();
    check("flush_hz", {31'b0, id_valid}, 32'h0);
    flush = 0; clear_fwd();

    // decode table
    if_instr = I_LUI;
    step();
    check("lui_imm", id_imm, 32'h8000_0000);
    check("lui_valid", {31'b0, id_valid}, 32'h1);
    if_instr = I_SW;
    step();
    check("sw_rd", {27'b0, id_rd}, 32'd0);
    if_instr = I_JAL;
    step();
    check("jal_rd", {27'b0, id_rd}, 32'd31);
    if_instr = I_LW;
    step();
    check("lw_isload", {31'b0, id_is_load}, 32'h1);
    check("lw_rd", {27'b0, id_rd}, 32'd4);

    // idle fetch produces no bundle
    if_valid = 0;
    step();
    check("idle_valid", {31'b0, id_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
